// File: rtl/aw_vm_thread_core.sv
// aw_vm_thread_core: multi-thread bytecode VM core.
// Once per frame it copies pending thread vectors into the PC table, then runs each active
// slot in ascending order until the thread yields or kills itself. Bytecode is fetched one
// byte per req/ack transaction. Opcodes not executed here go to a coprocessor via a trap
// handshake.
// Ports:
//   i_clk, i_rst_n                      clock, asynchronous active-low reset
//   i_frame_start                       pulse that starts a frame scan (ignored unless idle)
//   o_mem_req/o_mem_addr                byte fetch request, held until i_mem_ack
//   i_mem_ack/i_mem_rdata               fetch completion and fetched byte
//   o_trap_valid/o_trap_opcode/o_trap_pc unsupported opcode handed off, held until i_trap_ack
//   i_trap_ack/i_trap_next_pc           coprocessor done, resume address
//   o_busy, o_frame_done                scan in progress, 1-cycle end-of-frame pulse
//   o_fault, o_fault_code               sticky fault: 1 overflow, 2 underflow, 3 step limit
// NUM_THREADS and STACK_DEPTH must be powers of two.
module aw_vm_thread_core #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned NUM_THREADS = 64,
    parameter int unsigned NUM_VARS    = 256,
    parameter int unsigned STACK_DEPTH = 64,
    parameter int unsigned STEP_LIMIT  = 4096
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_frame_start,
    output logic              o_mem_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic              i_mem_ack,
    input  logic [7:0]        i_mem_rdata,
    output logic              o_trap_valid,
    output logic [7:0]        o_trap_opcode,
    output logic [ADDR_W-1:0] o_trap_pc,
    input  logic              i_trap_ack,
    input  logic [ADDR_W-1:0] i_trap_next_pc,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic              o_fault,
    output logic [1:0]        o_fault_code
);

    localparam int unsigned TW  = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
    localparam int unsigned VW  = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1;
    localparam int unsigned SW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int unsigned SPW = SW + 1;
    localparam int unsigned STW = (STEP_LIMIT > 0) ? $clog2(STEP_LIMIT + 1) : 1;

    localparam logic [ADDR_W-1:0] PcInactive = '1;
    // A pending vector of INACTIVE-1 kills the slot instead of jumping there.
    localparam logic [ADDR_W-1:0] PcKill     = PcInactive - ADDR_W'(1);

    typedef enum logic [3:0] {
        StIdle, StApply, StSelect, StFetch, StOper, StExec, StTrap, StDone, StFault
    } state_e;

    function automatic logic [VW-1:0] f_vidx(input logic [7:0] b);
        return VW'(32'(b) % NUM_VARS);
    endfunction

    function automatic logic [TW-1:0] f_tidx(input logic [7:0] b);
        return TW'(32'(b) % NUM_THREADS);
    endfunction

    // Operand bytes following the opcode; condJmp starts at 1 and is refined from its sub byte.
    function automatic logic [2:0] f_need(input logic [7:0] op);
        case (op)
            8'h00, 8'h03, 8'h08, 8'h09, 8'h16, 8'h17:        return 3'd3;
            8'h01, 8'h02, 8'h04, 8'h07, 8'h13, 8'h14, 8'h15: return 3'd2;
            8'h0A:                                           return 3'd1;
            default:                                         return 3'd0;
        endcase
    endfunction

    function automatic logic f_is_trap(input logic [7:0] op);
        case (op)
            8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A,
            8'h11, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17: return 1'b0;
            default:                                  return 1'b1;
        endcase
    endfunction

    // sub, v, operand (var byte / imm16 / imm8), a16
    function automatic logic [2:0] f_cj_need(input logic [7:0] sub);
        return sub[7] ? 3'd5 : (sub[6] ? 3'd6 : 3'd5);
    endfunction

    state_e              r_state;
    logic [ADDR_W-1:0]   r_pc_tab [NUM_THREADS];
    logic [ADDR_W-1:0]   r_pend   [NUM_THREADS];
    logic [15:0]         r_vars   [NUM_VARS];
    logic [ADDR_W-1:0]   r_stack  [STACK_DEPTH];
    logic [SPW-1:0]      r_sp;
    logic [STW-1:0]      r_steps;
    logic [TW:0]         r_slot;
    logic [TW-1:0]       r_cur;
    logic [ADDR_W-1:0]   r_pc;
    logic [7:0]          r_op;
    logic [7:0]          r_opnd [6];
    logic [2:0]          r_ocnt;
    logic [2:0]          r_oneed;
    logic                r_mem_req;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_trap_valid;
    logic [7:0]          r_trap_opcode;
    logic [ADDR_W-1:0]   r_trap_pc;
    logic                r_busy;
    logic                r_frame_done;
    logic                r_fault;
    logic [1:0]          r_fault_code;

    logic [TW-1:0]       w_slot_idx;
    logic [VW-1:0]       w_d;
    logic [15:0]         w_dv;
    logic [15:0]         w_sv;
    logic [15:0]         w_imm;
    logic [ADDR_W-1:0]   w_a01;
    logic [ADDR_W-1:0]   w_a12;
    logic [15:0]         w_res;
    logic                w_wr_var;
    logic [15:0]         w_cj_v;
    logic [15:0]         w_cj_b;
    logic [15:0]         w_cj_a;
    logic                w_cj_take;
    logic [SPW-1:0]      w_sp_m1;
    logic [2:0]          w_oper_need;

    assign w_slot_idx = r_slot[TW-1:0];
    assign w_sp_m1    = r_sp - SPW'(1);

    always_comb begin
        w_d         = f_vidx(r_opnd[0]);
        w_dv        = r_vars[w_d];
        w_sv        = r_vars[f_vidx(r_opnd[1])];
        w_imm       = {r_opnd[1], r_opnd[2]};
        w_a01       = ADDR_W'({r_opnd[0], r_opnd[1]});
        w_a12       = ADDR_W'({r_opnd[1], r_opnd[2]});
        w_oper_need = (r_op == 8'h0A && r_ocnt == 3'd0) ? f_cj_need(i_mem_rdata) : r_oneed;

        w_wr_var = 1'b1;
        w_res    = w_dv;
        case (r_op)
            8'h00:   w_res = w_imm;
            8'h01:   w_res = w_sv;
            8'h02:   w_res = w_dv + w_sv;
            8'h03:   w_res = w_dv + w_imm;
            8'h09:   w_res = w_dv - 16'd1;
            8'h13:   w_res = w_dv - w_sv;
            8'h14:   w_res = w_dv & w_sv;
            8'h15:   w_res = w_dv | w_sv;
            8'h16:   w_res = w_dv << w_imm[3:0];
            8'h17:   w_res = w_dv >> w_imm[3:0];
            default: w_wr_var = 1'b0;
        endcase

        w_cj_v = r_vars[f_vidx(r_opnd[1])];
        if (r_opnd[0][7]) begin
            w_cj_b = r_vars[f_vidx(r_opnd[2])];
            w_cj_a = {r_opnd[3], r_opnd[4]};
        end else if (r_opnd[0][6]) begin
            w_cj_b = {r_opnd[2], r_opnd[3]};
            w_cj_a = {r_opnd[4], r_opnd[5]};
        end else begin
            w_cj_b = {{8{r_opnd[2][7]}}, r_opnd[2]};
            w_cj_a = {r_opnd[3], r_opnd[4]};
        end
        case (r_opnd[0][2:0])
            3'd0:    w_cj_take = (w_cj_v == w_cj_b);
            3'd1:    w_cj_take = (w_cj_v != w_cj_b);
            3'd2:    w_cj_take = ($signed(w_cj_v) >  $signed(w_cj_b));
            3'd3:    w_cj_take = ($signed(w_cj_v) >= $signed(w_cj_b));
            3'd4:    w_cj_take = ($signed(w_cj_v) <  $signed(w_cj_b));
            3'd5:    w_cj_take = ($signed(w_cj_v) <= $signed(w_cj_b));
            default: w_cj_take = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            for (int i = 0; i < NUM_THREADS; i++) begin
                r_pc_tab[i] <= (i == 0) ? '0 : PcInactive;
                r_pend[i]   <= PcInactive;
            end
            for (int i = 0; i < NUM_VARS; i++) r_vars[i] <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) r_stack[i] <= '0;
            for (int i = 0; i < 6; i++) r_opnd[i] <= '0;
            r_sp          <= '0;
            r_steps       <= '0;
            r_slot        <= '0;
            r_cur         <= '0;
            r_pc          <= '0;
            r_op          <= '0;
            r_ocnt        <= '0;
            r_oneed       <= '0;
            r_mem_req     <= 1'b0;
            r_mem_addr    <= '0;
            r_trap_valid  <= 1'b0;
            r_trap_opcode <= '0;
            r_trap_pc     <= '0;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_fault       <= 1'b0;
            r_fault_code  <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    r_frame_done <= 1'b0;
                    if (i_frame_start) begin
                        r_busy  <= 1'b1;
                        r_slot  <= '0;
                        r_state <= StApply;
                    end
                end
                StApply: begin
                    if (r_pend[w_slot_idx] != PcInactive) begin
                        r_pc_tab[w_slot_idx] <= (r_pend[w_slot_idx] == PcKill) ? PcInactive
                                                                                 : r_pend[w_slot_idx];
                        r_pend[w_slot_idx]   <= PcInactive;
                    end
                    if (w_slot_idx == TW'(NUM_THREADS - 1)) begin
                        r_slot  <= '0;
                        r_state <= StSelect;
                    end else begin
                        r_slot <= r_slot + (TW+1)'(1);
                    end
                end
                StSelect: begin
                    if (r_slot[TW]) begin
                        r_state <= StDone;
                    end else if (r_pc_tab[w_slot_idx] == PcInactive) begin
                        r_slot <= r_slot + (TW+1)'(1);
                    end else begin
                        r_cur   <= w_slot_idx;
                        r_pc    <= r_pc_tab[w_slot_idx];
                        r_sp    <= '0;
                        r_steps <= '0;
                        r_slot  <= r_slot + (TW+1)'(1);
                        r_state <= StFetch;
                    end
                end
                StDone: begin
                    r_frame_done <= 1'b1;
                    r_busy       <= 1'b0;
                    r_state      <= StIdle;
                end
                StFetch: begin
                    if (!r_mem_req) begin
                        // Limit is checked before issuing the opcode fetch of the next instruction.
                        if (STEP_LIMIT != 0 && r_steps == STW'(STEP_LIMIT)) begin
                            r_fault      <= 1'b1;
                            r_fault_code <= 2'd3;
                            r_busy       <= 1'b0;
                            r_state      <= StFault;
                        end else begin
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= r_pc;
                        end
                    end else if (i_mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_op      <= i_mem_rdata;
                        r_pc      <= r_pc + ADDR_W'(1);
                        r_steps   <= r_steps + STW'(1);
                        r_ocnt    <= '0;
                        r_oneed   <= f_need(i_mem_rdata);
                        if (f_is_trap(i_mem_rdata)) begin
                            r_trap_valid  <= 1'b1;
                            r_trap_opcode <= i_mem_rdata;
                            r_trap_pc     <= r_pc + ADDR_W'(1);
                            r_state       <= StTrap;
                        end else if (f_need(i_mem_rdata) == 3'd0) begin
                            r_state <= StExec;
                        end else begin
                            r_state <= StOper;
                        end
                    end
                end
                StOper: begin
                    if (!r_mem_req) begin
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= r_pc;
                    end else if (i_mem_ack) begin
                        r_mem_req      <= 1'b0;
                        r_opnd[r_ocnt] <= i_mem_rdata;
                        r_pc           <= r_pc + ADDR_W'(1);
                        r_ocnt         <= r_ocnt + 3'd1;
                        r_oneed        <= w_oper_need;
                        if (r_ocnt + 3'd1 == w_oper_need) r_state <= StExec;
                    end
                end
                StExec: begin
                    r_state <= StFetch;
                    if (w_wr_var) r_vars[w_d] <= w_res;
                    case (r_op)
                        8'h04: begin
                            if (r_sp == SPW'(STACK_DEPTH)) begin
                                r_fault      <= 1'b1;
                                r_fault_code <= 2'd1;
                                r_busy       <= 1'b0;
                                r_state      <= StFault;
                            end else begin
                                r_stack[r_sp[SW-1:0]] <= r_pc;
                                r_sp                  <= r_sp + SPW'(1);
                                r_pc                  <= w_a01;
                            end
                        end
                        8'h05: begin
                            if (r_sp == '0) begin
                                r_fault      <= 1'b1;
                                r_fault_code <= 2'd2;
                                r_busy       <= 1'b0;
                                r_state      <= StFault;
                            end else begin
                                r_pc <= r_stack[w_sp_m1[SW-1:0]];
                                r_sp <= w_sp_m1;
                            end
                        end
                        8'h06: begin
                            r_pc_tab[r_cur] <= r_pc;
                            r_state         <= StSelect;
                        end
                        8'h07: r_pc <= w_a01;
                        // Only the pending table is written; it takes effect at the next APPLY.
                        8'h08: r_pend[f_tidx(r_opnd[0])] <= w_a12;
                        8'h09: if (w_res != 16'd0) r_pc <= w_a12;
                        8'h0A: if (w_cj_take) r_pc <= ADDR_W'(w_cj_a);
                        8'h11: begin
                            r_pc_tab[r_cur] <= PcInactive;
                            r_state         <= StSelect;
                        end
                        default: ;
                    endcase
                end
                StTrap: begin
                    if (i_trap_ack) begin
                        r_trap_valid <= 1'b0;
                        r_pc         <= i_trap_next_pc;
                        r_state      <= StFetch;
                    end
                end
                StFault: ;
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_mem_req     = r_mem_req;
    assign o_mem_addr    = r_mem_addr;
    assign o_trap_valid  = r_trap_valid;
    assign o_trap_opcode = r_trap_opcode;
    assign o_trap_pc     = r_trap_pc;
    assign o_busy        = r_busy;
    assign o_frame_done  = r_frame_done;
    assign o_fault       = r_fault;
    assign o_fault_code  = r_fault_code;

endmodule

// File: tb/tb_aw_vm_thread_core.sv
// Directed bench for aw_vm_thread_core with a byte memory responder and a trap responder.
module tb_aw_vm_thread_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_start;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        trap_valid;
    logic [7:0]  trap_opcode;
    logic [15:0] trap_pc;
    logic        trap_ack;
    logic [15:0] trap_next_pc;
    logic        busy;
    logic        frame_done;
    logic        fault;
    logic [1:0]  fault_code;

    always #5 clk = ~clk;

    aw_vm_thread_core dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_frame_start  (frame_start),
        .o_mem_req      (mem_req),
        .o_mem_addr     (mem_addr),
        .i_mem_ack      (mem_ack),
        .i_mem_rdata    (mem_rdata),
        .o_trap_valid   (trap_valid),
        .o_trap_opcode  (trap_opcode),
        .o_trap_pc      (trap_pc),
        .i_trap_ack     (trap_ack),
        .i_trap_next_pc (trap_next_pc),
        .o_busy         (busy),
        .o_frame_done   (frame_done),
        .o_fault        (fault),
        .o_fault_code   (fault_code)
    );

    logic [7:0]  mem [65536];
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          rand_delay = 1'b0;
    int          mem_wait = 0;
    int          mem_target = 0;
    int          trap_seen = 0;
    logic [7:0]  seen_op = '0;
    logic [15:0] seen_pc = '0;
    bit          trap_overlap = 1'b0;
    int          nd;

    initial begin
        mem_ack = 1'b0; mem_rdata = '0; trap_ack = 1'b0; trap_next_pc = 16'h0022;
    end

    // Memory: ack after a 0..7 cycle wait, one cycle wide.
    always @(negedge clk) begin
        if (!rst_n) begin
            mem_ack  = 1'b0;
            mem_wait = 0;
        end else if (mem_ack) begin
            mem_ack    = 1'b0;
            mem_wait   = 0;
            mem_target = rand_delay ? int'($urandom_range(0, 7)) : 0;
        end else if (mem_req) begin
            if (mem_wait >= mem_target) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr];
            end else begin
                mem_wait++;
            end
        end
    end

    always @(negedge clk) begin
        if (trap_valid && mem_req) trap_overlap = 1'b1;
        if (trap_ack) begin
            trap_ack = 1'b0;
        end else if (trap_valid) begin
            trap_seen++;
            seen_op  = trap_opcode;
            seen_pc  = trap_pc;
            trap_ack = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Filler 0x05 (ret at SP 0) makes any stray fetch fault.
    task automatic clear_mem();
        for (int i = 0; i < 65536; i++) mem[i] = 8'h05;
    endtask

    task automatic load(input int a, input int n, input logic [63:0] b);
        for (int i = 0; i < n; i++) mem[(a + i) & 16'hFFFF] = b[8*(n-1-i) +: 8];
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        frame_start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_frame(input int budget, output int ndone);
        ndone = 0;
        @(negedge clk) frame_start = 1'b1;
        @(negedge clk) frame_start = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (frame_done) ndone++;
            if (ndone > 0 || fault) break;
            @(negedge clk);
        end
        repeat (4) begin
            @(negedge clk);
            if (frame_done) ndone++;
        end
    endtask

    task automatic run_arith(input string tag);
        int n;
        clear_mem();
        load(0,  4, 64'h00011234);      // v1=0x1234
        load(4,  4, 64'h00020FF0);      // v2=0x0FF0
        load(8,  3, 64'h130102);        // v1-=v2 -> 0x0244
        load(11, 3, 64'h010302);        // v3=v2
        load(14, 3, 64'h140301);        // v3&=v1 -> 0x0240
        load(17, 3, 64'h150201);        // v2|=v1 -> 0x0FF4
        load(20, 4, 64'h16010004);      // v1<<=4 -> 0x2440
        load(24, 4, 64'h17020013);      // v2>>=3 -> 0x01FE
        load(28, 3, 64'h020202);        // v2+=v2 -> 0x03FC
        load(31, 4, 64'h00060003);      // v6=3
        load(35, 4, 64'h03070001);      // v7+=1
        load(39, 4, 64'h09060023);      // djnz v6,0x23
        load(43, 3, 64'h040040);        // call 0x40
        load(46, 1, 64'h06);            // yield
        load(64, 4, 64'h03080005);      // v8+=5
        load(68, 1, 64'h05);            // ret
        do_reset();
        run_frame(20000, n);
        check({tag, "_done"}, n, 1);
        check({tag, "_fault"}, fault, 0);
        check({tag, "_v1"}, dut.r_vars[1], 16'h2440);
        check({tag, "_v2"}, dut.r_vars[2], 16'h03FC);
        check({tag, "_v3"}, dut.r_vars[3], 16'h0240);
        check({tag, "_v6"}, dut.r_vars[6], 16'h0000);
        check({tag, "_v7"}, dut.r_vars[7], 16'h0003);
        check({tag, "_v8"}, dut.r_vars[8], 16'h0005);
        check({tag, "_pc0"}, dut.r_pc_tab[0], 16'h002F);
    endtask

    initial begin
        rst_n = 1'b0;
        frame_start = 1'b0;

        // Reset state and movConst/addConst/yield.
        clear_mem();
        load(0, 4, 64'h00051234);
        load(4, 4, 64'h0305FFFF);
        load(8, 1, 64'h06);
        do_reset();
        check("rst_busy", busy, 0);
        check("rst_req", mem_req, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_trap", trap_valid, 0);
        check("rst_done", frame_done, 0);
        check("rst_fault", {fault, fault_code}, 0);
        check("rst_pc0", dut.r_pc_tab[0], 16'h0000);
        check("rst_pc1", dut.r_pc_tab[1], 16'hFFFF);
        check("rst_pend0", dut.r_pend[0], 16'hFFFF);
        run_frame(5000, nd);
        check("t1_done", nd, 1);
        check("t1_v5", dut.r_vars[5], 16'h1233);
        check("t1_pc0", dut.r_pc_tab[0], 16'h0009);
        check("t1_busy", busy, 0);
        check("t1_fault", fault, 0);

        // condJmp signed lt, taken.
        clear_mem();
        load(0, 4, 64'h0001FFFE);
        load(4, 6, 64'h0A0401010020);
        load(10, 4, 64'h00020001);
        load(14, 1, 64'h06);
        load(32, 4, 64'h00030007);
        load(36, 1, 64'h06);
        do_reset();
        run_frame(5000, nd);
        check("cj_t_done", nd, 1);
        check("cj_t_v3", dut.r_vars[3], 16'h0007);
        check("cj_t_v2", dut.r_vars[2], 16'h0000);
        check("cj_t_pc0", dut.r_pc_tab[0], 16'h0025);

        // Same, v1=2: falls through.
        load(0, 4, 64'h00010002);
        do_reset();
        run_frame(5000, nd);
        check("cj_f_done", nd, 1);
        check("cj_f_v2", dut.r_vars[2], 16'h0001);
        check("cj_f_v3", dut.r_vars[3], 16'h0000);
        check("cj_f_pc0", dut.r_pc_tab[0], 16'h000F);

        // Arithmetic, djnz, call/ret with zero-wait memory.
        rand_delay = 1'b0;
        run_arith("ar0");

        // setVec / kill across frames.
        clear_mem();
        load(0, 4, 64'h08030100);
        load(4, 1, 64'h06);
        load(5, 4, 64'h000A0002);
        load(9, 1, 64'h06);
        load(10, 1, 64'h06);
        load(256, 3, 64'h02090A);
        load(259, 1, 64'h11);
        do_reset();
        run_frame(5000, nd);
        check("sv1_done", nd, 1);
        check("sv1_v9", dut.r_vars[9], 16'h0000);
        check("sv1_pc3", dut.r_pc_tab[3], 16'hFFFF);
        check("sv1_pend3", dut.r_pend[3], 16'h0100);
        check("sv1_pc0", dut.r_pc_tab[0], 16'h0005);
        run_frame(5000, nd);
        check("sv2_done", nd, 1);
        check("sv2_v9", dut.r_vars[9], 16'h0002);
        check("sv2_pc3", dut.r_pc_tab[3], 16'hFFFF);
        check("sv2_pc0", dut.r_pc_tab[0], 16'h000A);
        run_frame(5000, nd);
        check("sv3_done", nd, 1);
        check("sv3_v9", dut.r_vars[9], 16'h0002);
        check("sv3_pc0", dut.r_pc_tab[0], 16'h000B);

        // Stack overflow: recursive call to itself.
        clear_mem();
        load(0, 3, 64'h040000);
        do_reset();
        run_frame(5000, nd);
        check("ovf_done", nd, 0);
        check("ovf_fault", fault, 1);
        check("ovf_code", fault_code, 1);
        check("ovf_busy", busy, 0);
        check("ovf_sp", dut.r_sp, 64);
        run_frame(20, nd);
        check("ovf_ignore_done", nd, 0);
        check("ovf_ignore_busy", busy, 0);

        // Stack underflow.
        clear_mem();
        load(0, 1, 64'h05);
        do_reset();
        run_frame(5000, nd);
        check("unf_done", nd, 0);
        check("unf_fault", {fault, fault_code}, 3'b110);
        check("unf_busy", busy, 0);

        // Step limit: jmp to self.
        clear_mem();
        load(0, 3, 64'h070000);
        do_reset();
        run_frame(60000, nd);
        check("stp_done", nd, 0);
        check("stp_fault", {fault, fault_code}, 3'b111);
        check("stp_steps", dut.r_steps, 4096);

        // Trap handshake.
        clear_mem();
        load(0, 3, 64'h070020);
        load(32, 1, 64'h10);
        load(34, 4, 64'h000B002A);
        load(38, 1, 64'h06);
        trap_seen = 0;
        trap_overlap = 1'b0;
        trap_next_pc = 16'h0022;
        do_reset();
        run_frame(5000, nd);
        check("trp_done", nd, 1);
        check("trp_fault", fault, 0);
        check("trp_count", trap_seen, 1);
        check("trp_op", seen_op, 8'h10);
        check("trp_pc", seen_pc, 16'h0021);
        check("trp_overlap", trap_overlap, 0);
        check("trp_v11", dut.r_vars[11], 16'h002A);
        check("trp_pc0", dut.r_pc_tab[0], 16'h0027);

        // Random memory latency must give the same results.
        rand_delay = 1'b1;
        run_arith("ar_rnd");

        // Async reset while a fetch is outstanding.
        @(negedge clk) frame_start = 1'b1;
        @(negedge clk) frame_start = 1'b0;
        begin
            bit got;
            got = 1'b0;
            for (int c = 0; c < 1000; c++) begin
                @(posedge clk);
                #1;
                if (mem_req) begin
                    got = 1'b1;
                    break;
                end
            end
            check("arst_req_seen", got, 1);
        end
        rst_n = 1'b0;
        #1;
        check("arst_req", mem_req, 0);
        check("arst_busy", busy, 0);
        check("arst_v1", dut.r_vars[1], 16'h0000);
        check("arst_pc0", dut.r_pc_tab[0], 16'h0000);
        check("arst_fault", fault, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
